argmax_frame_ctrl: RTL and testbench

Sequencer between the final dense layer and the argmax unit.
- Collects one frame of DIM signed logits from a valid/ready stream into a register buffer.
- Presents the buffer to an external argmax instance, pulses its start, and waits for its done.
- Returns the winning class index on a valid/ready result port with error flags.
- Guards against frames of the wrong length and against an argmax that never completes.

---
 rtl/argmax_frame_ctrl_if.sv | 37 +++
 rtl/argmax_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_argmax_frame_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/argmax_frame_ctrl_if.sv
// Bundle of every non-clock signal of argmax_frame_ctrl.
//   in_*     : logit beat stream into the block (valid/ready, in_last marks end of frame)
//   am_*     : connection to the external argmax (start pulse, buffered vector, index, done)
//   out_*    : result stream (valid/ready) with winning class and error flags
//   busy, frame_count : status
// slave is the block's view, master is the view of the surrounding logic.
interface argmax_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIM        = 10,
  parameter int unsigned IDXW       = (DIM <= 1) ? 1 : $clog2(DIM),
  parameter int unsigned CNTW       = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_last;
  logic                         am_start;
  logic signed [DATA_WIDTH-1:0] am_vec [0:DIM-1];
  logic [IDXW-1:0]              am_idx;
  logic                         am_done;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDXW-1:0]              out_class;
  logic [1:0]                   out_err;
  logic                         busy;
  logic [CNTW-1:0]              frame_count;

  modport slave (
    input  in_valid, in_data, in_last, am_idx, am_done, out_ready,
    output in_ready, am_start, am_vec, out_valid, out_class, out_err, busy, frame_count
  );

  modport master (
    output in_valid, in_data, in_last, am_idx, am_done, out_ready,
    input  in_ready, am_start, am_vec, out_valid, out_class, out_err, busy, frame_count
  );
endinterface

// File: rtl/argmax_frame_ctrl.sv
// Sequencer between the last dense layer and an external argmax unit.
// Buffers one frame of DIM signed logits, starts the argmax, waits for its done
// (bounded by TIMEOUT) and returns the winning class with length/timeout flags.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : argmax_frame_ctrl_if.slave (input stream, argmax link, result stream, status)
module argmax_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIM        = 10,
  parameter int unsigned IDXW       = (DIM <= 1) ? 1 : $clog2(DIM),
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNTW       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  argmax_frame_ctrl_if.slave   bus
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDXW-1:0] LAST_PTR = IDXW'(DIM - 1);
  // Counter value in the final WAIT cycle: WAIT lasts TIMEOUT-1 cycles so that
  // out_valid rises exactly TIMEOUT cycles after am_start.
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    DRAIN   = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic [IDXW-1:0]              wr_ptr_q, wr_ptr_d;
  logic signed [DATA_WIDTH-1:0] buf_q [DIM];
  logic signed [DATA_WIDTH-1:0] buf_d [DIM];
  logic                         len_err_q, len_err_d;
  logic [TW-1:0]                tmo_q, tmo_d;
  logic                         in_ready_q, in_ready_d;
  logic                         am_start_q, am_start_d;
  logic                         out_valid_q, out_valid_d;
  logic [IDXW-1:0]              out_class_q, out_class_d;
  logic [1:0]                   out_err_q, out_err_d;
  logic                         busy_q, busy_d;
  logic [CNTW-1:0]              frame_count_q, frame_count_d;

  logic in_hs_c;
  logic out_hs_c;

  assign in_hs_c  = bus.in_valid && in_ready_q;
  assign out_hs_c = out_valid_q && bus.out_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= COLLECT;
      wr_ptr_q      <= '0;
      len_err_q     <= 1'b0;
      tmo_q         <= '0;
      in_ready_q    <= 1'b1;
      am_start_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_class_q   <= '0;
      out_err_q     <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      for (int i = 0; i < int'(DIM); i++) begin
        buf_q[i] <= MIN_VAL;
      end
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      len_err_q     <= len_err_d;
      tmo_q         <= tmo_d;
      in_ready_q    <= in_ready_d;
      am_start_q    <= am_start_d;
      out_valid_q   <= out_valid_d;
      out_class_q   <= out_class_d;
      out_err_q     <= out_err_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      buf_q         <= buf_d;
    end
  end

  // Next-state, buffer writes and registered-output targets
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    buf_d         = buf_q;
    len_err_d     = len_err_q;
    tmo_d         = tmo_q;
    out_valid_d   = out_valid_q;
    out_class_d   = out_class_q;
    out_err_d     = out_err_q;
    frame_count_d = frame_count_q;

    case (state_q)
      COLLECT: begin
        if (in_hs_c) begin
          buf_d[wr_ptr_q] = bus.in_data;
          if (bus.in_last) begin
            if (wr_ptr_q != LAST_PTR) begin
              // Short frame: pad the unfilled tail so it can never win.
              len_err_d = 1'b1;
              for (int i = 0; i < int'(DIM); i++) begin
                if (IDXW'(i) > wr_ptr_q) begin
                  buf_d[i] = MIN_VAL;
                end
              end
            end
            state_d = START;
          end else if (wr_ptr_q == LAST_PTR) begin
            len_err_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            wr_ptr_d = wr_ptr_q + IDXW'(1);
          end
        end
      end
      DRAIN: begin
        if (in_hs_c && bus.in_last) begin
          state_d = START;
        end
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done in the final timeout cycle still counts as a normal completion.
        if (bus.am_done) begin
          out_class_d = bus.am_idx;
          out_err_d   = {1'b0, len_err_q};
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else if (tmo_q == TMO_LAST) begin
          out_class_d = '0;
          out_err_d   = {1'b1, len_err_q};
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      OUTPUT: begin
        if (out_hs_c) begin
          out_valid_d   = 1'b0;
          frame_count_d = frame_count_q + CNTW'(1);
          len_err_d     = 1'b0;
          wr_ptr_d      = '0;
          state_d       = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Status outputs follow the next state so they are aligned with it
  always_comb begin
    in_ready_d = (state_d == COLLECT) || (state_d == DRAIN);
    am_start_d = (state_d == START);
    busy_d     = !((state_d == COLLECT) && (wr_ptr_d == '0));
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.am_start    = am_start_q;
  assign bus.am_vec      = buf_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_class   = out_class_q;
  assign bus.out_err     = out_err_q;
  assign bus.busy        = busy_q;
  assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_argmax_frame_ctrl.sv
// Directed bench for argmax_frame_ctrl with an argmax stub whose done latency
// is selectable (DIM+2 for the standard unit, 0 = never completes).
module tb_argmax_frame_ctrl;

  localparam int unsigned DW      = 16;
  localparam int unsigned DIM     = 10;
  localparam int unsigned IDXW    = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNTW    = 16;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  int stub_delay = 12;
  int stub_cnt = 0;
  int frame_q[$];
  int lat;

  argmax_frame_ctrl_if #(.DATA_WIDTH(DW), .DIM(DIM), .IDXW(IDXW), .CNTW(CNTW)) bus ();

  argmax_frame_ctrl #(
    .DATA_WIDTH(DW), .DIM(DIM), .IDXW(IDXW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int ref_argmax();
    int best = 0;
    for (int i = 1; i < int'(DIM); i++) begin
      if (bus.am_vec[i] > bus.am_vec[best]) best = i;
    end
    return best;
  endfunction

  // Argmax stub: done fires stub_delay cycles after the am_start cycle.
  always @(posedge clk) begin
    int nxt;
    bus.am_done <= 1'b0;
    nxt = bus.am_start ? 1 : ((stub_cnt > 0) ? stub_cnt + 1 : 0);
    if (nxt != 0 && nxt == stub_delay) begin
      bus.am_done <= 1'b1;
      bus.am_idx  <= IDXW'(ref_argmax());
      stub_cnt    <= 0;
    end else begin
      stub_cnt <= nxt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send frame_q as one frame, in_last on its final beat.
  task automatic send_frame(input bit check_ready);
    for (int i = 0; i < frame_q.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(frame_q[i]);
      bus.in_last  = (i == frame_q.size() - 1);
      if (check_ready) chk("in_ready_beat", {31'd0, bus.in_ready}, 32'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("am_start", {31'd0, bus.am_start}, 32'd1);
  endtask

  // Cycles from the am_start cycle until out_valid, bounded.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!bus.out_valid) chk("out_valid_wait", 32'd0, 32'd1);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_fc++;
    chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("frame_count", {16'd0, bus.frame_count}, 32'(exp_fc));
  endtask

  task automatic run_frame(input string tag, input int exp_lat, input int exp_cls,
                           input int exp_err);
    send_frame(1'b0);
    wait_out(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_class"}, {28'd0, bus.out_class}, 32'(exp_cls));
    chk({tag, "_err"}, {30'd0, bus.out_err}, 32'(exp_err));
    accept();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.am_idx    = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_am_start", {31'd0, bus.am_start}, 32'd0);
    chk("rst_fc", {16'd0, bus.frame_count}, 32'd0);
    chk("rst_err", {30'd0, bus.out_err}, 32'd0);
    chk("rst_vec0", {16'd0, bus.am_vec[0]}, 32'h8000);

    // Normal frame: max 12 at index 7
    frame_q = '{3, -2, 5, 1, 0, 9, -7, 12, 4, 2};
    run_frame("normal", 13, 7, 0);

    // Tie between indices 2 and 6: first one wins
    frame_q = '{-100, -100, -1, -100, -100, -100, -1, -100, -100, -100};
    run_frame("tie", 13, 2, 0);

    // Early last after 4 beats: tail padded with most-negative
    frame_q = '{-5, -3, -1, -4};
    send_frame(1'b0);
    chk("early_vec3", {16'd0, bus.am_vec[3]}, 32'hFFFC);
    chk("early_vec4", {16'd0, bus.am_vec[4]}, 32'h8000);
    chk("early_vec9", {16'd0, bus.am_vec[9]}, 32'h8000);
    wait_out(lat);
    chk("early_class", {28'd0, bus.out_class}, 32'd2);
    chk("early_err", {30'd0, bus.out_err}, 32'd1);
    accept();

    // Long frame: 12 beats, the 11th beat (100) must be dropped
    frame_q = '{0, 1, 2, 3, 50, 4, 5, 6, 7, 8, 100, 0};
    send_frame(1'b1);
    wait_out(lat);
    chk("long_class", {28'd0, bus.out_class}, 32'd4);
    chk("long_err", {30'd0, bus.out_err}, 32'd1);
    accept();
    frame_q = '{3, -2, 5, 1, 0, 9, -7, 12, 4, 2};
    run_frame("after_long", 13, 7, 0);

    // Timeout: argmax never completes
    stub_delay = 0;
    run_frame("timeout", int'(TIMEOUT), 0, 2);

    // Done on the last timeout cycle is a normal completion
    stub_delay = int'(TIMEOUT) - 1;
    run_frame("late_done", int'(TIMEOUT), 7, 0);

    // Backpressure: result held for 5 cycles
    stub_delay = 12;
    send_frame(1'b0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_class", {28'd0, bus.out_class}, 32'd7);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    accept();

    // Reset mid-WAIT; the stub's late done must be ignored
    send_frame(1'b0);
    tick();
    tick();
    tick();
    chk("wait_in_ready", {31'd0, bus.in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_fc = 0;
    chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_fc", {16'd0, bus.frame_count}, 32'd0);
    chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("late_done_ignored", {31'd0, bus.out_valid}, 32'd0);
    chk("late_done_idle", {31'd0, bus.busy}, 32'd0);

    // Clean frame after reset
    run_frame("post_rst", 13, 7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
